// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the IF-stage program-counter / next-PC unit.
// Contents: the ID-stage branch and jump opcode encodings, the fetch
// state encodings, the default reset PC, and a branch offset helper.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10
  } br_op_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JAL  = 2'b10,
    JMP_JR   = 2'b11
  } jmp_op_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_e;

  // Sign-extended word offset of a branch immediate (imm16 << 2).
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational redirect decode for the instruction currently in ID.
// Ports:
//   id_br_op, id_jmp_op  - branch / jump opcode of the ID instruction
//   id_pc                - PC of the ID instruction
//   id_imm16, id_index26 - branch offset and j/jal index fields
//   id_rs_val            - forwarded rs value (jr target)
//   cmp_zero             - ID comparator result, 1 when rs == rt
//   redirect             - the instruction redirects (taken branch or jump)
//   target               - redirect target address
// Validity of the ID slot and stall gating are applied by the caller.
module pc_fetch_unit_npc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [1:0]  id_br_op,
  input  logic [1:0]  id_jmp_op,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_val,
  input  logic        cmp_zero,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // Branch target is relative to the delay-slot address (id_pc + 4).
  assign br_target = id_pc + 32'd4 + branch_offset(id_imm16);
  assign j_target  = {id_pc[31:28], id_index26, 2'b00};

  // Jumps take priority over branch decode; the two are never both
  // set by a real decoder.
  always_comb begin
    redirect = 1'b0;
    target   = br_target;
    case (id_jmp_op)
      JMP_J, JMP_JAL: begin
        redirect = 1'b1;
        target   = j_target;
      end
      JMP_JR: begin
        redirect = 1'b1;
        target   = id_rs_val;
      end
      default: begin
        case (id_br_op)
          BR_BEQ:  redirect = cmp_zero;
          BR_BNE:  redirect = !cmp_zero;
          default: redirect = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter and next-PC unit of the 5-stage MIPS pipeline.
// Resolves branch / jump redirects coming from ID with delayed-branch
// semantics and issues instruction-memory fetches.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   stall                - hazard stall, ID frozen (no redirect resolves)
//   id_valid             - ID holds a real instruction
//   id_br_op, id_jmp_op  - opcode of the ID instruction
//   id_pc, id_imm16, id_index26, id_rs_val, cmp_zero - redirect operands
//   imem_req, imem_addr  - fetch request and its address
//   imem_ready           - fetch completes this cycle
//   if_pc, if_valid      - PC of the word being fetched, word valid this cycle
//   redirect_pending     - a resolved target waits for the delay-slot delivery
//   fsm_state            - current fetch state (fetch_state_e encoding)
//
// Handshake: a fetch completes in a cycle where imem_req && imem_ready.
// imem_addr is stable while imem_req is high and not ready. The completed
// word is presented with if_valid; ID takes it ("delivery") in any cycle
// with if_valid && !stall, otherwise it is held (HOLD, imem_req low) until
// stall drops.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [1:0]      id_br_op,
  input  logic [1:0]      id_jmp_op,
  input  logic [PC_W-1:0] id_pc,
  input  logic [15:0]     id_imm16,
  input  logic [25:0]     id_index26,
  input  logic [PC_W-1:0] id_rs_val,
  input  logic            cmp_zero,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            redirect_pending,
  output logic [1:0]      fsm_state
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic            id_redirect;
  logic [PC_W-1:0] id_target;
  logic            resolve;
  logic            deliver;

  pc_fetch_unit_npc_calc u_npc_calc (
    .id_br_op   (id_br_op),
    .id_jmp_op  (id_jmp_op),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs_val  (id_rs_val),
    .cmp_zero   (cmp_zero),
    .redirect   (id_redirect),
    .target     (id_target)
  );

  // A redirect only resolves while ID actually advances.
  assign resolve = id_valid && !stall && id_redirect;

  // Fetch FSM: outputs and delivery strobe.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    if_valid = 1'b0;
    deliver  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if_valid = 1'b1;
          if (stall) state_d = ST_HOLD;
          else       deliver = 1'b1;
        end
      end
      ST_HOLD: begin
        if_valid = 1'b1;
        if (!stall) begin
          deliver = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Next PC and pending target. The PC only moves when the current word
  // (possibly a delay slot) reaches ID; a redirect resolving without a
  // delivery is parked until that delivery happens.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (deliver) begin
      pend_valid_d = 1'b0;
      if (pend_valid_q) pc_d = pend_tgt_q;
      else if (resolve) pc_d = id_target;
      else              pc_d = pc_q + PC_W'(4);
    end else if (resolve) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = id_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC[PC_W-1:0];
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign if_pc            = pc_q;
  assign imem_addr        = pc_q;
  assign redirect_pending = pend_valid_q;
  assign fsm_state        = state_q;

  // While a target is pending ID can only hold bubbles, so a second
  // redirect must never resolve on top of it.
  a_single_pending_redirect: assert property (
    @(posedge clk) disable iff (!reset_n) !(pend_valid_q && resolve)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        stall, id_valid, cmp_zero, imem_ready;
  logic [1:0]  id_br_op, id_jmp_op;
  logic [31:0] id_pc, id_rs_val;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic        imem_req, if_valid, redirect_pending;
  logic [31:0] imem_addr, if_pc;
  logic [1:0]  fsm_state;

  pc_fetch_unit #(.PC_W(32), .RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .id_valid         (id_valid),
    .id_br_op         (id_br_op),
    .id_jmp_op        (id_jmp_op),
    .id_pc            (id_pc),
    .id_imm16         (id_imm16),
    .id_index26       (id_index26),
    .id_rs_val        (id_rs_val),
    .cmp_zero         (cmp_zero),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .redirect_pending (redirect_pending),
    .fsm_state        (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];  // addresses expected to be delivered to ID, in order

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a word is fetched at m_pc; once fetched but not
  // taken by ID it is "held"; a resolved target waits in m_pend until
  // the delay slot reaches ID. m_id_* mirrors what the ID stage holds.
  logic [31:0] m_pc, m_pend_tgt, m_id_pc;
  bit          m_boot, m_held, m_pend, m_id_valid;

  task automatic model_reset();
    m_pc       = RST_PC;
    m_boot     = 1'b1;
    m_held     = 1'b0;
    m_pend     = 1'b0;
    m_pend_tgt = '0;
    m_id_valid = 1'b0;
    m_id_pc    = '0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    stall = 1'b0; imem_ready = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_br_op = BR_NONE; id_jmp_op = JMP_NONE; id_imm16 = '0;
    id_index26 = '0; id_rs_val = '0; cmp_zero = 1'b0;
  endtask

  // Asserts reset at posedge+1 (asynchronously), checks reset values,
  // releases one edge later. Leaves the bench at posedge+1.
  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check_eq("rst_if_pc", if_pc, RST_PC);
    check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_pending", {31'b0, redirect_pending}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("boot_imem_req", {31'b0, imem_req}, 32'd0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit st, input bit rdy, input logic [1:0] br, input logic [1:0] jmp,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                      input bit cz);
    bit          exp_req, exp_vld, dlv, res, taken;
    logic [31:0] tgt, n_pc, n_pend_tgt, n_id_pc;
    bit          n_pend, n_held, n_id_valid;
    int          off;

    stall = st; imem_ready = rdy;
    id_valid = m_id_valid; id_pc = m_id_pc;
    id_br_op = br; id_jmp_op = jmp; id_imm16 = imm; id_index26 = idx;
    id_rs_val = rs; cmp_zero = cz;

    exp_req = !m_boot && !m_held;
    exp_vld = m_held || (exp_req && rdy);
    dlv     = exp_vld && !st;

    @(negedge clk);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, exp_vld});
    check_eq("if_pc", if_pc, m_pc);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
    if (dlv) exp_q.push_back(m_pc);
    check_eq("delivered", {31'b0, if_valid && !stall}, {31'b0, dlv});
    if (dlv && exp_q.size() > 0) check_eq("delivered_pc", if_pc, exp_q.pop_front());

    // Redirect from the instruction sitting in ID.
    off   = $signed(imm);
    taken = (jmp != JMP_NONE) || (br == BR_BEQ && cz) || (br == BR_BNE && !cz);
    if (jmp == JMP_JR)                      tgt = rs;
    else if (jmp == JMP_J || jmp == JMP_JAL) tgt = {m_id_pc[31:28], idx, 2'b00};
    else                                    tgt = m_id_pc + 32'd4 + 32'(off * 4);
    res = m_id_valid && !st && taken;

    n_pc = m_pc; n_pend = m_pend; n_pend_tgt = m_pend_tgt;
    if (dlv) begin
      n_pend = 1'b0;
      if (m_pend)   n_pc = m_pend_tgt;
      else if (res) n_pc = tgt;
      else          n_pc = m_pc + 32'd4;
    end else if (res) begin
      n_pend = 1'b1; n_pend_tgt = tgt;
    end

    n_held = m_held;
    if (m_held && !st)                n_held = 1'b0;
    else if (exp_req && rdy && st)    n_held = 1'b1;

    n_id_valid = m_id_valid; n_id_pc = m_id_pc;
    if (dlv) begin n_id_valid = 1'b1; n_id_pc = m_pc; end
    else if (!st) n_id_valid = 1'b0;

    @(posedge clk);
    #1;
    m_pc = n_pc; m_pend = n_pend; m_pend_tgt = n_pend_tgt; m_held = n_held;
    m_id_valid = n_id_valid; m_id_pc = n_id_pc; m_boot = 1'b0;
  endtask

  task automatic idle(input bit st, input bit rdy);
    step(st, rdy, BR_NONE, JMP_NONE, 16'h0, 26'h0, 32'h0, 1'b0);
  endtask

  task automatic rand_step();
    int          kind;
    logic [1:0]  br, jmp;
    br = BR_NONE; jmp = JMP_NONE;
    kind = $urandom_range(0, 5);
    case (kind)
      2: br  = BR_BEQ;
      3: br  = BR_BNE;
      4: jmp = ($urandom_range(0, 1) == 0) ? JMP_J : JMP_JAL;
      5: jmp = JMP_JR;
      default: ;
    endcase
    step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, br, jmp,
         16'($urandom), 26'($urandom), 32'($urandom), 1'($urandom));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;

    // Straight-line fetch after reset.
    do_reset();
    idle(0, 1); check_eq("seq_addr0", imem_addr, 32'h3000);
    check_eq("seq_req_on", {31'b0, imem_req}, 32'd1);
    idle(0, 1); check_eq("seq_addr1", imem_addr, 32'h3004);
    idle(0, 1); check_eq("seq_addr2", imem_addr, 32'h3008);
    // beq at 0x3004 taken; delay slot 0x3008 delivered this cycle.
    step(0, 1, BR_BEQ, JMP_NONE, 16'h0003, 26'h0, 32'h0, 1'b1);
    check_eq("beq_target", if_pc, 32'h3014);
    check_eq("beq_no_pending", {31'b0, redirect_pending}, 32'd0);

    // bne with equal operands: no redirect.
    do_reset();
    repeat (3) idle(0, 1);
    step(0, 1, BR_BNE, JMP_NONE, 16'h0003, 26'h0, 32'h0, 1'b1);
    check_eq("bne_fallthrough", if_pc, 32'h300C);

    // jr resolving while the delay-slot fetch is stalled by memory.
    do_reset();
    repeat (3) idle(0, 1);
    step(0, 0, BR_NONE, JMP_JR, 16'h0, 26'h0, 32'h0000_4000, 1'b0);
    check_eq("jr_pend_a", {31'b0, redirect_pending}, 32'd1);
    check_eq("jr_slot_held", if_pc, 32'h3008);
    idle(0, 0); check_eq("jr_pend_b", {31'b0, redirect_pending}, 32'd1);
    idle(0, 0); check_eq("jr_pend_c", {31'b0, redirect_pending}, 32'd1);
    idle(0, 1); check_eq("jr_target", if_pc, 32'h0000_4000);
    check_eq("jr_pend_clear", {31'b0, redirect_pending}, 32'd0);

    // Stall for two cycles across a completed fetch.
    idle(1, 1);
    check_eq("hold_req", {31'b0, imem_req}, 32'd0);
    check_eq("hold_pc", if_pc, 32'h0000_4000);
    idle(1, 0);
    check_eq("hold_pc2", if_pc, 32'h0000_4000);
    check_eq("hold_valid", {31'b0, if_valid}, 32'd1);
    idle(0, 0); check_eq("hold_release", if_pc, 32'h0000_4004);
    idle(0, 0); check_eq("hold_once", if_pc, 32'h0000_4004);

    // Reset while a redirect is pending: target is lost.
    do_reset();
    repeat (3) idle(0, 1);
    step(0, 0, BR_NONE, JMP_J, 16'h0, 26'h0000_800, 32'h0, 1'b0);
    check_eq("mid_pend", {31'b0, redirect_pending}, 32'd1);
    do_reset();
    idle(0, 1); check_eq("restart_addr0", if_pc, 32'h3000);
    idle(0, 1); check_eq("restart_addr1", if_pc, 32'h3004);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else rand_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
